// File: rtl/cart_mbc_bank.sv
// MBC1-class cartridge bank controller: decodes CPU register writes into
// ROM/RAM bank selects and produces flat byte addresses for the cart arrays.
module cart_mbc_bank #(
    parameter int ROM_BANKS = 64,
    parameter int RAM_BANKS = 4,
    parameter int ROM_AW    = $clog2(ROM_BANKS) + 14,
    parameter int RAM_AW    =
        (($clog2((RAM_BANKS > 1) ? RAM_BANKS : 1) > 1)
            ? $clog2((RAM_BANKS > 1) ? RAM_BANKS : 1) : 1) + 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       A,
    input  logic [7:0]        Do,
    input  logic              wr_n,
    input  logic              rd_n,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [7:0]        ram_rdata,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic              cart_sel,
    output logic [7:0]        cart_rdata
);

    localparam logic [6:0] ROM_MASK = 7'(ROM_BANKS - 1);
    localparam logic [1:0] RAM_MASK =
        (RAM_BANKS > 1) ? 2'(RAM_BANKS - 1) : 2'd0;
    localparam bit HAS_RAM = (RAM_BANKS > 0);

    logic              ram_en_q, ram_en_d;
    logic [4:0]        bank_lo_q, bank_lo_d;
    logic [1:0]        bank_hi_q, bank_hi_d;
    logic              mode_q, mode_d;
    logic              wr_q, wr_d;
    logic              ram_we_q, ram_we_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic [RAM_AW-1:0] ram_waddr_q, ram_waddr_d;

    logic       strobe;
    logic       in_rom;
    logic       in_ram;
    logic       ram_live;
    logic [6:0] rom_bank;
    logic [1:0] ram_bank;
    logic       unused_rd;

    // Reads are zero-latency and side-effect free, so the read strobe
    // carries no information the mapper needs.
    assign unused_rd = rd_n;

    assign strobe   = !wr_n && wr_q;
    assign in_rom   = !A[15];
    assign in_ram   = (A[15:13] == 3'b101);
    assign ram_live = HAS_RAM && ram_en_q && in_ram;

    always_comb begin
        rom_bank = 7'd0;
        if (in_rom) begin
            if (A[14]) begin
                rom_bank = {bank_hi_q, bank_lo_q};
            end else if (mode_q) begin
                rom_bank = {bank_hi_q, 5'd0};
            end
        end
        rom_bank = rom_bank & ROM_MASK;
        rom_addr = ROM_AW'({rom_bank, A[13:0]});
        ram_bank = (mode_q ? bank_hi_q : 2'd0) & RAM_MASK;
        ram_addr = RAM_AW'({ram_bank, A[12:0]});
    end

    always_comb begin
        cart_sel   = in_rom || in_ram;
        cart_rdata = 8'hFF;
        if (in_rom) begin
            cart_rdata = rom_rdata;
        end else if (ram_live) begin
            cart_rdata = ram_rdata;
        end
    end

    always_comb begin
        ram_en_d    = ram_en_q;
        bank_lo_d   = bank_lo_q;
        bank_hi_d   = bank_hi_q;
        mode_d      = mode_q;
        wr_d        = wr_n;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        ram_waddr_d = ram_waddr_q;
        if (strobe) begin
            unique case (A[15:13])
                3'b000: ram_en_d = (Do[3:0] == 4'hA);
                3'b001: bank_lo_d = (Do[4:0] == 5'd0) ? 5'd1 : Do[4:0];
                3'b010: bank_hi_d = Do[1:0];
                3'b011: mode_d = Do[0];
                default: ;
            endcase
            if (ram_live) begin
                ram_we_d    = 1'b1;
                ram_wdata_d = Do;
                ram_waddr_d = ram_addr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ram_en_q    <= 1'b0;
            bank_lo_q   <= 5'd1;
            bank_hi_q   <= 2'd0;
            mode_q      <= 1'b0;
            wr_q        <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 8'd0;
            ram_waddr_q <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            bank_lo_q   <= bank_lo_d;
            bank_hi_q   <= bank_hi_d;
            mode_q      <= mode_d;
            wr_q        <= wr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            ram_waddr_q <= ram_waddr_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_waddr = ram_waddr_q;

endmodule

// File: tb/tb_cart_mbc_bank.sv
// Scoreboard bench for cart_mbc_bank with a 2 MiB ROM and 4 RAM banks.
module tb_cart_mbc_bank;

    localparam int ROMB = 128;
    localparam int RAMB = 4;
    localparam int RAW  = 21;
    localparam int MAW  = 15;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [15:0]    A     = 16'h0000;
    logic [7:0]     Do    = 8'h00;
    logic           wr_n  = 1'b1;
    logic           rd_n  = 1'b1;
    logic [RAW-1:0] rom_addr;
    logic [7:0]     rom_rdata;
    logic [MAW-1:0] ram_addr;
    logic [7:0]     ram_rdata;
    logic           ram_we;
    logic [7:0]     ram_wdata;
    logic [MAW-1:0] ram_waddr;
    logic           cart_sel;
    logic [7:0]     cart_rdata;

    cart_mbc_bank #(.ROM_BANKS(ROMB), .RAM_BANKS(RAMB)) dut (
        .clock(clock), .reset(reset), .A(A), .Do(Do),
        .wr_n(wr_n), .rd_n(rd_n),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_waddr(ram_waddr),
        .cart_sel(cart_sel), .cart_rdata(cart_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] rom_model(logic [31:0] a);
        return a[7:0] ^ {a[20:14], 1'b1};
    endfunction

    function automatic logic [7:0] ram_model(logic [31:0] a);
        return 8'(a[7:0] + {1'b0, a[14:8]} + 8'h11);
    endfunction

    assign rom_rdata = rom_model(32'(rom_addr));
    assign ram_rdata = ram_model(32'(ram_addr));

    typedef enum int {
        K_ROMA, K_RAMA, K_SEL, K_RDATA, K_WE, K_WADDR, K_WDATA
    } kind_e;

    typedef struct {
        kind_e       kind;
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(kind_e k, string tag, logic [31:0] e);
        exp_t it;
        it.kind = k;
        it.tag  = tag;
        it.exp  = e;
        sb.push_back(it);
    endtask

    task automatic drain();
        exp_t        it;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.kind)
                K_ROMA:  obs = 32'(rom_addr);
                K_RAMA:  obs = 32'(ram_addr);
                K_SEL:   obs = 32'(cart_sel);
                K_RDATA: obs = 32'(cart_rdata);
                K_WE:    obs = 32'(ram_we);
                K_WADDR: obs = 32'(ram_waddr);
                default: obs = 32'(ram_wdata);
            endcase
            check(it.tag, obs, it.exp);
        end
    endtask

    task automatic cpu_write(logic [15:0] addr, logic [7:0] data,
                             logic we, logic [31:0] waddr,
                             logic [31:0] wdata);
        @(negedge clock);
        A    = addr;
        Do   = data;
        wr_n = 1'b0;
        push(K_WE, "we_after_strobe", 32'(we));
        if (we) begin
            push(K_WADDR, "waddr", waddr);
            push(K_WDATA, "wdata", wdata);
        end
        @(negedge clock);
        drain();
        wr_n = 1'b1;
        push(K_WE, "we_one_cycle", 32'd0);
        @(negedge clock);
        drain();
    endtask

    task automatic rd_rom(logic [15:0] addr, logic [31:0] exp);
        @(negedge clock);
        A = addr;
        push(K_ROMA, "rom_addr", exp);
        push(K_SEL, "sel_rom", 32'd1);
        push(K_RDATA, "rdata_rom", 32'(rom_model(exp)));
        #1 drain();
    endtask

    task automatic rd_ram(logic [15:0] addr, logic [31:0] exp, logic live);
        @(negedge clock);
        A = addr;
        push(K_RAMA, "ram_addr", exp);
        push(K_SEL, "sel_ram", 32'd1);
        push(K_RDATA, "rdata_ram",
             live ? 32'(ram_model(exp)) : 32'h0000_00FF);
        #1 drain();
    endtask

    task automatic rd_off(logic [15:0] addr);
        @(negedge clock);
        A = addr;
        push(K_SEL, "sel_off", 32'd0);
        push(K_RDATA, "rdata_off", 32'h0000_00FF);
        #1 drain();
    endtask

    task automatic reset_with_write(logic [15:0] addr, logic [7:0] data);
        @(negedge clock);
        A     = addr;
        Do    = data;
        wr_n  = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wr_n  = 1'b1;
        push(K_WE, "we_in_reset", 32'd0);
        #1 drain();
        @(negedge clock);
        push(K_WE, "we_after_reset", 32'd0);
        #1 drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        push(K_WE, "we_reset", 32'd0);
        push(K_WADDR, "waddr_reset", 32'd0);
        push(K_WDATA, "wdata_reset", 32'd0);
        #1 drain();
        rd_rom(16'h4123, 32'h04123);
        rd_rom(16'h0123, 32'h00123);
        rd_off(16'h8000);
        rd_ram(16'hA010, 32'h0010, 1'b0);

        // One strobe for a long low pulse, even across an address change.
        @(negedge clock);
        A    = 16'h2000;
        Do   = 8'h05;
        wr_n = 1'b0;
        @(negedge clock);
        A  = 16'h2001;
        Do = 8'h07;
        repeat (3) @(negedge clock);
        wr_n = 1'b1;
        rd_rom(16'h4000, 32'h14000);

        cpu_write(16'h2100, 8'h00, 1'b0, 0, 0);
        rd_rom(16'h4000, 32'h04000);
        cpu_write(16'h2000, 8'h20, 1'b0, 0, 0);
        rd_rom(16'h4000, 32'h04000);
        cpu_write(16'h4000, 8'h01, 1'b0, 0, 0);
        cpu_write(16'h6000, 8'h01, 1'b0, 0, 0);
        rd_rom(16'h4000, 32'h84000);
        rd_rom(16'h0000, 32'h80000);
        cpu_write(16'h6000, 8'h00, 1'b0, 0, 0);
        rd_rom(16'h0000, 32'h00000);

        cpu_write(16'hA010, 8'h55, 1'b0, 0, 0);
        rd_ram(16'hA010, 32'h0010, 1'b0);
        cpu_write(16'h0000, 8'h0A, 1'b0, 0, 0);
        rd_ram(16'hA010, 32'h0010, 1'b1);
        cpu_write(16'hA010, 8'h55, 1'b1, 32'h0010, 32'h55);

        cpu_write(16'h6000, 8'h01, 1'b0, 0, 0);
        cpu_write(16'h4000, 8'h02, 1'b0, 0, 0);
        cpu_write(16'hB000, 8'h99, 1'b1, 32'h5000, 32'h99);
        rd_ram(16'hB000, 32'h5000, 1'b1);
        rd_rom(16'h0000, 32'h100000);
        cpu_write(16'h6000, 8'h00, 1'b0, 0, 0);
        rd_ram(16'hB000, 32'h1000, 1'b1);
        rd_rom(16'h4000, 32'h104000);

        cpu_write(16'h8000, 8'h03, 1'b0, 0, 0);
        rd_rom(16'h4000, 32'h104000);
        rd_off(16'hC000);

        cpu_write(16'h0000, 8'h00, 1'b0, 0, 0);
        rd_ram(16'hA000, 32'h0000, 1'b0);

        cpu_write(16'h0000, 8'h0A, 1'b0, 0, 0);
        reset_with_write(16'hA010, 8'h77);
        rd_ram(16'hA010, 32'h0010, 1'b0);

        cpu_write(16'h2000, 8'h03, 1'b0, 0, 0);
        rd_rom(16'h4000, 32'h0C000);
        reset_with_write(16'h2000, 8'h1F);
        rd_rom(16'h4000, 32'h04000);
        rd_ram(16'hA000, 32'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
